// File: rtl/pe_pkg.sv
// Shared helpers for PE post-processing: width math and output saturation limits.
package pe_pkg;

    localparam int OUT_W_DEF = 8;
    localparam int OUT_MAX   = (1 << OUT_W_DEF) - 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Full-precision width of a sum of num_rows signed in_w-bit values.
    function automatic int sum_width(input int in_w, input int num_rows);
        return in_w + clog2(num_rows);
    endfunction

    function automatic int out_max(input int out_w);
        return (1 << out_w) - 1;
    endfunction

endpackage

// File: rtl/pe_sat_clamp.sv
// Combinational arithmetic shift and unsigned clamp of a signed SW-bit value.
// Define PE_COL_SUM_ROUND_EN for round-half-up before the shift; default is floor.
module pe_sat_clamp
    import pe_pkg::*;
#(
    parameter int SW      = 13,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic [SW-1:0]      i_val,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_val,
    output logic               o_hi,
    output logic               o_lo
);

    logic signed [SW:0] w_ext;
    logic signed [SW:0] w_rnd;
    logic signed [SW:0] w_sh;
    logic               w_big;

    // One extra bit so the rounding offset can never overflow.
    assign w_ext = {i_val[SW-1], i_val};

`ifdef PE_COL_SUM_ROUND_EN
    logic signed [SW:0] w_half;

    always_comb begin
        w_half = '0;
        if (i_shift != '0) begin
            w_half = (SW+1)'(1) << (i_shift - SHIFT_W'(1));
        end
    end

    assign w_rnd = w_ext + w_half;
`else
    assign w_rnd = w_ext;
`endif

    assign w_sh  = w_rnd >>> i_shift;
    assign w_big = |w_sh[SW-1:OUT_W];

    always_comb begin
        o_val = w_sh[OUT_W-1:0];
        o_hi  = 1'b0;
        o_lo  = 1'b0;
        if (w_sh[SW]) begin
            o_val = '0;
            o_lo  = 1'b1;
        end else if (w_big) begin
            o_val = OUT_W'(out_max(OUT_W));
            o_hi  = 1'b1;
        end
    end

endmodule

// File: rtl/pe_col_sum_sat.sv
// Two-stage PE column sum with shift, unsigned saturation, valid/ready and clamp counter.
// Rounding mode selected by PE_COL_SUM_ROUND_EN (see pe_sat_clamp).
module pe_col_sum_sat
    import pe_pkg::*;
#(
    parameter int NUM_ROWS = 3,
    parameter int IN_W     = 11,
    parameter int OUT_W    = 8,
    parameter int SHIFT_W  = 3,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_ROWS*IN_W-1:0] i_rows,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [SHIFT_W-1:0]       i_shift,
    output logic [OUT_W-1:0]         o_sum,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_sat_hi,
    output logic                     o_sat_lo,
    input  logic                     i_cnt_clr,
    output logic [CNT_W-1:0]         o_sat_cnt
);

    localparam int SW = sum_width(IN_W, NUM_ROWS);

    logic signed [SW-1:0] w_sum;
    logic                 w_en;
    logic [OUT_W-1:0]     w_c_sum;
    logic                 w_c_hi;
    logic                 w_c_lo;
    logic                 w_cnt_inc;

    logic [SW-1:0]        r_s1_sum;
    logic [SHIFT_W-1:0]   r_s1_shift;
    logic                 r_s1_valid;
    logic [OUT_W-1:0]     r_sum;
    logic                 r_valid;
    logic                 r_hi;
    logic                 r_lo;
    logic [CNT_W-1:0]     r_cnt;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_ROWS; k++) begin
            w_sum = w_sum + SW'($signed(i_rows[k*IN_W +: IN_W]));
        end
    end

    // Whole pipeline advances together; a full, stalled output freezes both stages.
    assign w_en    = !r_valid || i_ready;
    assign o_ready = w_en;

    pe_sat_clamp #(
        .SW      (SW),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_clamp (
        .i_val   (r_s1_sum),
        .i_shift (r_s1_shift),
        .o_val   (w_c_sum),
        .o_hi    (w_c_hi),
        .o_lo    (w_c_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sum   <= '0;
            r_s1_shift <= '0;
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_valid    <= 1'b0;
            r_hi       <= 1'b0;
            r_lo       <= 1'b0;
        end else if (w_en) begin
            r_s1_sum   <= w_sum;
            r_s1_shift <= i_shift;
            r_s1_valid <= i_valid;
            r_sum      <= w_c_sum;
            r_valid    <= r_s1_valid;
            r_hi       <= r_s1_valid & w_c_hi;
            r_lo       <= r_s1_valid & w_c_lo;
        end
    end

    assign w_cnt_inc = r_valid & i_ready & (r_hi | r_lo) & ~(&r_cnt);

    always_ff @(posedge clk) begin
        if (rst || i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_sum     = r_sum;
    assign o_valid   = r_valid;
    assign o_sat_hi  = r_hi;
    assign o_sat_lo  = r_lo;
    assign o_sat_cnt = r_cnt;

endmodule

// File: tb/tb_pe_col_sum_sat.sv
// Directed self-checking bench for pe_col_sum_sat (default width and 2-bit counter instances).
module tb_pe_col_sum_sat;

    localparam int NUM_ROWS = 3;
    localparam int IN_W     = 11;
    localparam int OUT_W    = 8;
    localparam int SHIFT_W  = 3;
    localparam int CNT_W    = 16;

`ifdef PE_COL_SUM_ROUND_EN
    localparam int EXP_351_S1 = 176;
    localparam int EXP_3_S2   = 1;
`else
    localparam int EXP_351_S1 = 175;
    localparam int EXP_3_S2   = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_ROWS*IN_W-1:0] i_rows;
    logic                     i_valid;
    logic                     o_ready;
    logic [SHIFT_W-1:0]       i_shift;
    logic [OUT_W-1:0]         o_sum;
    logic                     o_valid;
    logic                     i_ready;
    logic                     o_sat_hi;
    logic                     o_sat_lo;
    logic                     i_cnt_clr;
    logic [CNT_W-1:0]         o_sat_cnt;

    logic                     o_ready2;
    logic [OUT_W-1:0]         o_sum2;
    logic                     o_valid2;
    logic                     o_sat_hi2;
    logic                     o_sat_lo2;
    logic [1:0]               o_sat_cnt2;

    int checks = 0;
    int errors = 0;
    int in_idx;
    int out_idx;
    int v;

    always #5 clk = ~clk;

    pe_col_sum_sat #(
        .NUM_ROWS (NUM_ROWS), .IN_W (IN_W), .OUT_W (OUT_W),
        .SHIFT_W (SHIFT_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst), .i_rows (i_rows), .i_valid (i_valid),
        .o_ready (o_ready), .i_shift (i_shift), .o_sum (o_sum),
        .o_valid (o_valid), .i_ready (i_ready), .o_sat_hi (o_sat_hi),
        .o_sat_lo (o_sat_lo), .i_cnt_clr (i_cnt_clr), .o_sat_cnt (o_sat_cnt)
    );

    pe_col_sum_sat #(
        .NUM_ROWS (NUM_ROWS), .IN_W (IN_W), .OUT_W (OUT_W),
        .SHIFT_W (SHIFT_W), .CNT_W (2)
    ) dut_c2 (
        .clk (clk), .rst (rst), .i_rows (i_rows), .i_valid (i_valid),
        .o_ready (o_ready2), .i_shift (i_shift), .o_sum (o_sum2),
        .o_valid (o_valid2), .i_ready (i_ready), .o_sat_hi (o_sat_hi2),
        .o_sat_lo (o_sat_lo2), .i_cnt_clr (i_cnt_clr), .o_sat_cnt (o_sat_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_ROWS*IN_W-1:0] pack(input int a, input int b, input int c);
        return {IN_W'(c), IN_W'(b), IN_W'(a)};
    endfunction

    // Push one sample into an empty pipe, check it two edges later, then let it transfer.
    task automatic run_one(input string tag, input int r0, input int r1, input int r2,
                           input int sh, input int es, input int eh, input int el);
        i_rows  = pack(r0, r1, r2);
        i_shift = SHIFT_W'(sh);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk({tag, " s1_latency"}, 32'(o_valid), 0);
        tick();
        chk({tag, " valid"}, 32'(o_valid), 1);
        chk({tag, " sum"}, 32'(o_sum), 32'(es));
        chk({tag, " hi"}, 32'(o_sat_hi), 32'(eh));
        chk({tag, " lo"}, 32'(o_sat_lo), 32'(el));
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        i_rows    = '0;
        i_valid   = 1'b0;
        i_shift   = '0;
        i_ready   = 1'b1;
        i_cnt_clr = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        chk("rst o_valid", 32'(o_valid), 0);
        chk("rst o_sum", 32'(o_sum), 0);
        chk("rst hi", 32'(o_sat_hi), 0);
        chk("rst lo", 32'(o_sat_lo), 0);
        chk("rst cnt", 32'(o_sat_cnt), 0);
        chk("rst o_ready", 32'(o_ready), 1);

        run_one("pass175", 100, 50, 25, 0, 175, 0, 0);
        chk("pass175 cnt", 32'(o_sat_cnt), 0);
        run_one("hi350", 200, 100, 50, 0, 255, 1, 0);
        chk("hi350 cnt", 32'(o_sat_cnt), 1);
        run_one("shift350", 200, 100, 50, 1, 175, 0, 0);
        chk("shift350 cnt", 32'(o_sat_cnt), 1);
        run_one("lo-150", -300, 100, 50, 0, 0, 0, 1);
        chk("lo-150 cnt", 32'(o_sat_cnt), 2);
        run_one("min", -1024, -1024, -1024, 0, 0, 0, 1);
        run_one("max", 1023, 1023, 1023, 0, 255, 1, 0);
        chk("max cnt", 32'(o_sat_cnt), 4);
        run_one("rnd351", 200, 100, 51, 1, EXP_351_S1, 0, 0);
        run_one("rnd3", 1, 1, 1, 2, EXP_3_S2, 0, 0);
        run_one("edge255", 255, 0, 0, 0, 255, 0, 0);
        run_one("edge256", 256, 0, 0, 0, 255, 1, 0);
        chk("five clamps cnt", 32'(o_sat_cnt), 5);
        chk("cnt2 saturates", 32'(o_sat_cnt2), 3);

        // Clear coinciding with a clamped output transfer.
        i_rows  = pack(256, 0, 0);
        i_shift = '0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("clr pre hi", 32'(o_sat_hi), 1);
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        chk("clr cnt", 32'(o_sat_cnt), 0);
        chk("clr cnt2", 32'(o_sat_cnt2), 0);

        // Stream of 8 with a 3-cycle downstream stall.
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
            i_ready = !(cyc >= 4 && cyc <= 6);
            i_valid = (in_idx < 8);
            i_rows  = pack(100 + 30 * in_idx, 0, 0);
            i_shift = '0;
            #1;
            if (o_valid) begin
                v = 100 + 30 * out_idx;
                chk("bp sum", 32'(o_sum), (v > 255) ? 255 : 32'(v));
                chk("bp hi", 32'(o_sat_hi), (v > 255) ? 1 : 0);
                chk("bp lo", 32'(o_sat_lo), 0);
                if (!i_ready) begin
                    chk("bp ready low", 32'(o_ready), 0);
                end else begin
                    out_idx++;
                end
            end
            if (i_valid && o_ready) begin
                in_idx++;
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp all in", 32'(in_idx), 8);
        chk("bp all out", 32'(out_idx), 8);
        tick();
        tick();
        chk("bp no dup", 32'(o_valid), 0);
        chk("bp cnt", 32'(o_sat_cnt), 2);
        chk("bp cnt2", 32'(o_sat_cnt2), 2);

        // Reset with two clamped samples in flight.
        i_rows  = pack(300, 0, 0);
        i_valid = 1'b1;
        tick();
        tick();
        chk("flight valid", 32'(o_valid), 1);
        rst     = 1'b1;
        i_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst valid", 32'(o_valid), 0);
        chk("midrst sum", 32'(o_sum), 0);
        chk("midrst cnt", 32'(o_sat_cnt), 0);
        chk("midrst cnt2", 32'(o_sat_cnt2), 0);
        tick();
        chk("midrst discard", 32'(o_valid), 0);
        chk("midrst ready", 32'(o_ready), 1);
        chk("midrst cnt after", 32'(o_sat_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
